// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Constants and state encoding for the nibble-serial adder/subtractor.
package nibble_serial_adder_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_adder4.sv
// 4-bit ripple adder with carry in/out; the only adder in the datapath.
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    sum  = full[3:0];
    cout = full[4];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract controller: one 4-bit adder time-shared over
// WIDTH/4 nibbles, LSB nibble first, with final carry and signed overflow.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sub_q, sub_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;
  logic                carry_into_msb;

  // Subtraction is A + ~B + 1: B is inverted here and the +1 comes from carry_q.
  always_comb begin
    nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
  end

  adder4 u_adder4 (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Carry into the nibble's top bit, recovered from its sum bit.
  assign carry_into_msb = nib_sum[NIBBLE_W-1] ^ nib_a[NIBBLE_W-1] ^ nib_b[NIBBLE_W-1];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          idx_d   = '0;
          carry_d = sub;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_sum;
        carry_d = nib_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = nib_cout;
          ovf_d   = carry_into_msb ^ nib_cout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed, table-driven bench for nibble_serial_adder_ctrl at WIDTH=16.
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned W   = 16;
  localparam int          NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for IDLE, issues one operation, returns edges from the accepting
  // edge up to and including the edge that first samples done high.
  task automatic do_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1; sub = s; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    lat = lat + 1;
  endtask

  initial begin
    int lat;
    int n;
    int t_done[3];
    bit seen;
    logic [W-1:0] exp3[3];

    vecs[0] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   32'(busy),   32'd0);
    chk("reset_done",   32'(done),   32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_cout",   32'(cout),   32'd0);
    chk("reset_ovf",    32'(ovf),    32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].sub, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat),         32'(NIB + 1));
      chk($sformatf("vec%0d_result", i),  32'(result),      32'(vecs[i].res));
      chk($sformatf("vec%0d_cout", i),    32'(cout),        32'(vecs[i].cout));
      chk($sformatf("vec%0d_ovf", i),     32'(ovf),         32'(vecs[i].ovf));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), 32'(done),     32'd0);
      chk($sformatf("vec%0d_hold", i),    32'({result, cout, ovf}),
          32'({vecs[i].res, vecs[i].cout, vecs[i].ovf}));
    end

    // start pulses during RUN and during DONE must be ignored
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; sub = 1'b1; a = 16'hFFFF; b = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ign_run_done",   32'(done),   32'd1);
    chk("ign_run_result", 32'(result), 32'h3333);
    chk("ign_run_cout",   32'(cout),   32'd0);
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 16'h0F00; b = 16'h0F00;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_done_busy",   32'(busy),   32'd0);
    chk("ign_done_result", 32'(result), 32'h3333);
    @(posedge clk); #1;
    chk("ign_done_noqueue", 32'(busy),  32'd0);

    // reset on the second RUN edge aborts without a done pulse
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h1111;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy",   32'(busy),   32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_done",   32'(done),   32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    do_op(1'b0, 16'h1234, 16'h1111, lat);
    chk("abort_fresh_latency", 32'(lat),    32'(NIB + 1));
    chk("abort_fresh_result",  32'(result), 32'h2345);

    // start held high for three back-to-back operations
    exp3[0] = 16'h0003; exp3[1] = 16'h000F; exp3[2] = 16'h0100;
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 16'h0001; b = 16'h0002;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n = 0;
      while (!done && n < 30) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("held%0d_done", k),   32'(done),   32'd1);
      chk($sformatf("held%0d_result", k), 32'(result), 32'(exp3[k]));
      t_done[k] = cyc;
      @(negedge clk);
      if (k == 0) begin sub = 1'b1; a = 16'h0010; b = 16'h0001; end
      else if (k == 1) begin sub = 1'b0; a = 16'h00FF; b = 16'h0001; end
      else start = 1'b0;
    end
    chk("held_spacing_1", 32'(t_done[1] - t_done[0]), 32'(NIB + 2));
    chk("held_spacing_2", 32'(t_done[2] - t_done[1]), 32'(NIB + 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
